// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encodings, FSM states and the NZVC flag record.
package alu_pkg;

  // 3-bit op field as presented on cntrl.
  typedef enum logic [2:0] {
    OpPassB = 3'b000,
    OpMul   = 3'b001,
    OpAdd   = 3'b010,
    OpSub   = 3'b011,
    OpAnd   = 3'b100,
    OpOr    = 3'b101,
    OpXor   = 3'b110,
    OpLsl   = 3'b111
  } alu_op_t;

  // Handshake FSM: single-cycle ops complete from StIdle, MUL walks StMul -> StDone.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDone = 2'b10
  } alu_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  localparam flags_t FlagsClear = '{n: 1'b0, z: 1'b0, v: 1'b0, c: 1'b0};

  // Assemble a flag record from the result's MSB, its zero test and the adder's V/C.
  function automatic flags_t pack_flags(input logic msb, input logic is_zero,
                                        input logic v, input logic c);
    flags_t f;
    f.n = msb;
    f.z = is_zero;
    f.v = v;
    f.c = c;
    return f;
  endfunction

  // Only the adder ops produce meaningful carry/overflow.
  function automatic logic is_arith(input alu_op_t op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// Only the low WIDTH bits of the product are kept.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             last_step;

  // The step taken this cycle is the final one; the accumulator is complete after this edge.
  assign last_step = busy_q && (cnt_q == CntLast);

  // Next-state: load on start, otherwise add-if-LSB-set and shift while busy.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      // Bits shifted out of the multiplicand only affect the discarded upper product half.
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_step) begin
        busy_d = 1'b0;
      end
    end
  end

  // Multiplier state registers; reset discards any in-flight product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = last_step;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU behind a valid/ready handshake. Single-cycle ops complete one cycle
// after acceptance; MUL is handed to the iterative multiplier. A persistent NZVC register is
// written only by ops issued with set_flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             mul_sf_q, mul_sf_d;

  alu_op_t          op;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] add_res;
  logic             add_c;
  logic             add_v;
  logic             msb_carry_in;

  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_c;

  assign op        = alu_op_t'(cntrl);
  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OpMul);

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (A),
    .b      (B),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Shared ADD/SUB adder: cntrl[0] selects subtract by inverting B and injecting carry-in.
  always_comb begin
    b_op         = cntrl[0] ? ~B : B;
    sum_ext      = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cntrl[0]};
    add_res      = sum_ext[WIDTH-1:0];
    add_c        = sum_ext[WIDTH];
    // Recover the carry into the MSB from the MSB sum bit and its two operand bits.
    msb_carry_in = A[WIDTH-1] ^ b_op[WIDTH-1] ^ add_res[WIDTH-1];
    add_v        = msb_carry_in ^ add_c;
  end

  // Single-cycle op mux; C and V are only driven by the adder ops.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    unique case (op)
      OpPassB: alu_res = B;
      OpMul:   alu_res = '0;  // completes through the multiplier path
      OpAdd,
      OpSub: begin
        alu_res = add_res;
        alu_v   = add_v;
        alu_c   = add_c;
      end
      OpAnd:   alu_res = A & B;
      OpOr:    alu_res = A | B;
      OpXor:   alu_res = A ^ B;
      OpLsl:   alu_res = A << B[SHW-1:0];
      default: alu_res = '0;
    endcase
    if (!is_arith(op)) begin
      alu_v = 1'b0;
      alu_c = 1'b0;
    end
  end

  // Handshake FSM next-state plus result/flag/completion updates.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    mul_sf_d    = mul_sf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OpMul) begin
            mul_sf_d = set_flags;
            state_d  = StMul;
          end else begin
            result_d    = alu_res;
            out_valid_d = 1'b1;
            if (set_flags) begin
              flags_d = pack_flags(alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c);
            end
          end
        end
      end
      StMul: begin
        if (mul_busy && mul_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        result_d    = mul_product;
        out_valid_d = 1'b1;
        if (mul_sf_q) begin
          flags_d = pack_flags(mul_product[WIDTH-1], mul_product == '0, 1'b0, 1'b0);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, result and flag registers; reset abandons an in-flight MUL without a completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      result_q    <= '0;
      flags_q     <= FlagsClear;
      out_valid_q <= 1'b0;
      mul_sf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      mul_sf_q    <= mul_sf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign negative  = flags_q.n;
  assign zero      = flags_q.z;
  assign overflow  = flags_q.v;
  assign carry_out = flags_q.c;

endmodule
